// File: rtl/conv2d_stream.sv
// Streaming KxK 2D convolution: raster pixels in, one saturated result per
// fully populated window out. Serially loaded signed kernel, valid/ready on both sides.
module conv2d_stream #(
    parameter int DATA_W    = 9,
    parameter int COEF_W    = 9,
    parameter int K         = 3,
    parameter int IMG_W_MAX = 16,
    parameter int SHIFT     = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$clog2(IMG_W_MAX+1)-1:0]   cfg_img_w,
    input  logic                             k_wr_en,
    input  logic [COEF_W-1:0]                k_data,
    input  logic                             k_clear,
    output logic                             k_loaded,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    input  logic                             pix_sof,
    input  logic [DATA_W-1:0]                pix_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data
);
    localparam int KK    = K * K;
    localparam int IDX_W = $clog2(KK + 1);
    localparam int COL_W = $clog2(IMG_W_MAX + 1);
    localparam int AW    = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;
    localparam int ROW_W = $clog2(K);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(KK) + 1;

    localparam logic [IDX_W-1:0] KK_I      = IDX_W'(KK);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_KM1   = COL_W'(K - 1);
    localparam logic [COL_W-1:0] IMG_W_RST = COL_W'(IMG_W_MAX);
    localparam logic signed [ACC_W-1:0] MAX_S = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     k_loaded_q, k_loaded_d;
    logic                     kernel_we;
    logic signed [COEF_W-1:0] coef_q [KK];

    logic [COL_W-1:0]  col_q, col_d, img_w_q, img_w_d, cur_col, cur_w;
    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic [AW-1:0]     lb_addr;
    logic              accept, win_valid;

    logic [DATA_W-1:0] w_q [K][K];
    logic [DATA_W-1:0] w_d [K][K];
    logic [DATA_W-1:0] lb_rd [K-1];
    logic [DATA_W-1:0] new_col [K];

    logic signed [ACC_W-1:0] acc, acc_sh;
    logic [DATA_W-1:0]       sat;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    assign pix_ready = k_loaded_q & (~out_valid_q | out_ready);
    assign accept    = pix_valid & pix_ready;
    assign k_loaded  = k_loaded_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // sof redefines the accepted pixel as (0,0) and swaps in the new width.
    assign cur_col   = pix_sof ? '0 : col_q;
    assign cur_row   = pix_sof ? '0 : row_q;
    assign cur_w     = pix_sof ? cfg_img_w : img_w_q;
    assign lb_addr   = cur_col[AW-1:0];
    assign win_valid = (cur_row == ROW_MAX) && (cur_col >= COL_KM1);

    always_comb begin
        idx_d      = idx_q;
        k_loaded_d = k_loaded_q;
        kernel_we  = 1'b0;
        if (k_clear) begin
            idx_d      = '0;
            k_loaded_d = 1'b0;
        end else if (!k_loaded_q) begin
            if (idx_q == KK_I) begin
                k_loaded_d = 1'b1;
            end else if (k_wr_en) begin
                kernel_we = 1'b1;
                idx_d     = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        img_w_d = img_w_q;
        if (accept) begin
            img_w_d = cur_w;
            if (cur_col == cur_w - 1'b1) begin
                col_d = '0;
                row_d = (cur_row == ROW_MAX) ? cur_row : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    // Line buffer 0 holds the previous row; each further buffer is one row older.
    genvar gi, gj;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            logic [DATA_W-1:0] mem [IMG_W_MAX];
            logic [DATA_W-1:0] wr_data;
            assign lb_rd[gi] = mem[lb_addr];
            if (gi == 0) begin : g_first
                assign wr_data = pix_data;
            end else begin : g_chain
                assign wr_data = lb_rd[gi-1];
            end
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[lb_addr] <= wr_data;
                end
            end
            assign new_col[gi] = lb_rd[K-2-gi];
        end
        assign new_col[K-1] = pix_data;

        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K - 1; gj++) begin : g_col
                assign w_d[gi][gj] = w_q[gi][gj+1];
            end
            assign w_d[gi][K-1] = new_col[gi];
        end
    endgenerate

    // Result is taken from the window including the pixel being accepted.
    always_comb begin
        acc = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                acc = acc + $signed({{(ACC_W-DATA_W){1'b0}}, w_d[r][c]})
                          * $signed({{(ACC_W-COEF_W){coef_q[KK-1-r*K-c][COEF_W-1]}},
                                     coef_q[KK-1-r*K-c]});
            end
        end
        acc_sh = acc >>> SHIFT;
        if (acc_sh[ACC_W-1]) begin
            sat = '0;
        end else if (acc_sh > MAX_S) begin
            sat = '1;
        end else begin
            sat = acc_sh[DATA_W-1:0];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept && win_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = sat;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (kernel_we) begin
            coef_q[idx_q] <= k_data;
        end
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    w_q[r][c] <= w_d[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            k_loaded_q  <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            img_w_q     <= IMG_W_RST;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            idx_q       <= idx_d;
            k_loaded_q  <= k_loaded_d;
            col_q       <= col_d;
            row_q       <= row_d;
            img_w_q     <= img_w_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream: reference convolution over a stored image,
// expected results queued at pixel acceptance and compared as outputs are consumed.
module tb_conv2d_stream;
    logic       clk;
    logic       reset;
    logic [4:0] cfg_img_w;
    logic       k_wr_en;
    logic [8:0] k_data;
    logic       k_clear;
    logic       k_loaded, k_loaded2;
    logic       pix_valid;
    logic       pix_ready, pix_ready2;
    logic       pix_sof;
    logic [8:0] pix_data;
    logic       out_valid, out_valid2;
    logic       out_ready;
    logic [8:0] out_data, out_data2;

    int checks = 0;
    int errors = 0;
    int q0[$];
    int q2[$];
    int cur_coef[9];
    int img[16][16];
    int br = 0, bc = 0, bw = 16;

    conv2d_stream dut (
        .clk(clk), .reset(reset), .cfg_img_w(cfg_img_w),
        .k_wr_en(k_wr_en), .k_data(k_data), .k_clear(k_clear), .k_loaded(k_loaded),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    conv2d_stream #(.SHIFT(2)) dut_s2 (
        .clk(clk), .reset(reset), .cfg_img_w(cfg_img_w),
        .k_wr_en(k_wr_en), .k_data(k_data), .k_clear(k_clear), .k_loaded(k_loaded2),
        .pix_valid(pix_valid), .pix_ready(pix_ready2), .pix_sof(pix_sof), .pix_data(pix_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_ref(input int a, input int sh);
        int v;
        v = a >>> sh;
        if (v < 0) return 0;
        if (v > 511) return 511;
        return v;
    endfunction

    task automatic model_accept(input int v, input bit sof);
        int acc;
        if (sof) begin
            br = 0; bc = 0; bw = int'(cfg_img_w);
        end
        if (br < 16 && bc < 16) img[br][bc] = v;
        if (br >= 2 && bc >= 2) begin
            acc = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    acc += img[br-2+r][bc-2+c] * cur_coef[8-(r*3+c)];
            q0.push_back(sat_ref(acc, 0));
            q2.push_back(sat_ref(acc, 2));
        end
        if (bc == bw - 1) begin
            bc = 0; br++;
        end else begin
            bc++;
        end
    endtask

    // Scoreboard: every consumed output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            chk("out0_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) chk("out0_data", 32'(out_data), 32'(q0.pop_front()));
        end
        if (out_valid2 && out_ready) begin
            chk("out2_expected", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) chk("out2_data", 32'(out_data2), 32'(q2.pop_front()));
        end
    end

    task automatic send_pix(input int v, input bit sof);
        int n;
        pix_valid = 1'b1; pix_data = 9'(v); pix_sof = sof;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!pix_ready && n < 200);
        chk("pix_accept", 32'(pix_ready), 1);
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
        model_accept(v, sof);
    endtask

    task automatic load_kernel();
        int n;
        for (int i = 0; i < 9; i++) begin
            k_wr_en = 1'b1; k_data = 9'(cur_coef[i]);
            if (i == 8) begin
                @(negedge clk);
                chk("ready_before_9th", 32'(pix_ready), 0);
            end
            @(posedge clk); #1;
        end
        k_wr_en = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!k_loaded && n < 20);
        chk("k_loaded", 32'(k_loaded), 1);
        @(posedge clk); #1;
    endtask

    task automatic clear_kernel();
        k_clear = 1'b1;
        @(posedge clk); #1;
        k_clear = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q2.size()) != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        chk("drain", 32'(q0.size() + q2.size()), 0);
        @(posedge clk); #1;
    endtask

    // Frame of pixel values base + step*i; optional 3-cycle output stall at first result.
    task automatic run_frame(input int w, input int h, input int base, input int step, input bit hold);
        int held;
        cfg_img_w = 5'(w);
        for (int i = 0; i < w * h; i++) begin
            if (i == 2 * w + 2) begin
                @(negedge clk);
                chk("no_early_out", 32'(out_valid), 0);
                @(posedge clk); #1;
            end
            send_pix(base + step * i, i == 0);
            if (i == 2 * w + 2) begin
                if (hold) out_ready = 1'b0;
                @(negedge clk);
                chk("latency", 32'(out_valid), 1);
                if (hold) begin
                    held = (q0.size() != 0) ? q0[0] : -1;
                    pix_valid = 1'b1; pix_data = 9'(base + step * (i + 1)); pix_sof = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        if (k > 0) @(negedge clk);
                        chk("hold_valid", 32'(out_valid), 1);
                        chk("hold_ready", 32'(pix_ready), 0);
                        chk("hold_data", 32'(out_data), 32'(held));
                    end
                    @(posedge clk); #1;
                    out_ready = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; cfg_img_w = 5'd5; k_wr_en = 1'b0; k_data = '0; k_clear = 1'b0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_k_loaded", 32'(k_loaded), 0);
        chk("rst_pix_ready", 32'(pix_ready), 0);
        @(posedge clk); #1;

        // Identity kernel at centre, then a 10th write that must be ignored.
        for (int i = 0; i < 9; i++) cur_coef[i] = (i == 4) ? 1 : 0;
        load_kernel();
        k_wr_en = 1'b1; k_data = 9'd255;
        @(posedge clk); #1;
        k_wr_en = 1'b0;
        run_frame(5, 5, 0, 1, 1'b0);
        drain();

        // Clear wins over a simultaneous write; then flipped-kernel check with backpressure.
        k_clear = 1'b1; k_wr_en = 1'b1; k_data = 9'd7;
        @(posedge clk); #1;
        k_clear = 1'b0; k_wr_en = 1'b0;
        @(negedge clk);
        chk("clr_k_loaded", 32'(k_loaded), 0);
        chk("clr_pix_ready", 32'(pix_ready), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) cur_coef[i] = (i == 0) ? 1 : 0;
        load_kernel();
        run_frame(5, 5, 0, 1, 1'b1);
        drain();

        // New sof arriving as the 14th pixel of a frame restarts window gating.
        cfg_img_w = 5'd5;
        for (int i = 0; i < 13; i++) send_pix(i, i == 0);
        run_frame(5, 5, 50, 1, 1'b0);
        drain();

        // Negative saturation, then positive saturation and shifted result.
        clear_kernel();
        for (int i = 0; i < 9; i++) cur_coef[i] = -1;
        load_kernel();
        run_frame(3, 3, 100, 0, 1'b0);
        drain();
        clear_kernel();
        for (int i = 0; i < 9; i++) cur_coef[i] = 1;
        load_kernel();
        run_frame(3, 3, 100, 0, 1'b0);
        drain();

        // Reset while a result is pending.
        cfg_img_w = 5'd3;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_pix(100, i == 0);
        @(negedge clk);
        chk("pend_valid", 32'(out_valid), 1);
        chk("pend_data", 32'(out_data), 511);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        q0.delete(); q2.delete();
        br = 0; bc = 0; bw = 16;
        @(negedge clk);
        chk("rst2_out_valid", 32'(out_valid), 0);
        chk("rst2_out_data", 32'(out_data), 0);
        chk("rst2_k_loaded", 32'(k_loaded), 0);
        chk("rst2_pix_ready", 32'(pix_ready), 0);
        chk("rst2_out_valid_s2", 32'(out_valid2), 0);
        chk("rst2_pix_ready_s2", 32'(pix_ready2), 0);
        @(posedge clk); #1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
